policy_gen: RTL and testbench
=============================

POLICY_GEN -- requirements
Module: policy_gen

Interface
REQ-001 Parameter OWN_MARK, default 2'd1, cell code of the mark this block plays; the opponent code is its bitwise inverse (2'd2).
REQ-002 Parameter LFSR_SEED, default 8'hA5, reset value of the tie-break LFSR; a value of 0 SHALL be replaced by 8'h01.
REQ-003 Port clock, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port enable, input, 1, low: FSM held in IDLE, LFSR frozen.
REQ-006 Port rst_policygen, input, 1, synchronous clear: FSM to IDLE, LFSR reloaded with LFSR_SEED.
REQ-007 Port board, input, 18, cell i at [2i+1:2i]; 00 empty, 01 agent, 10 player, 11 counted as occupied.
REQ-008 Port outcome, input, 2, game result; any nonzero value means the game is over.
REQ-009 Port req, input, 1, move request, sampled in IDLE only.
REQ-010 Port action_ready, input, 1, consumer accepts action.
REQ-011 Port action, output, 4, chosen cell index, 0..8.
REQ-012 Port action_valid, output, 1, action holds a legal move.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port no_move, output, 1, one-cycle pulse when the snapshot has no empty cell.

Function
REQ-015 The FSM SHALL have states IDLE, WIN, BLOCK, CENTER, RAND, HOLD.
REQ-016 IDLE: when req=1, enable=1 and outcome=0, the block SHALL latch board into a snapshot register, clear the line counter, and go to WIN; later board changes SHALL be ignored until return to IDLE.
REQ-017 Line order: L0 {0,1,2}, L1 {3,4,5}, L2 {6,7,8}, L3 {0,3,6}, L4 {1,4,7}, L5 {2,5,8}, L6 {0,4,8}, L7 {2,4,6}.
REQ-018 WIN SHALL examine one line per cycle, in order L0..L7; a hit is two OWN_MARK cells plus one empty cell.
REQ-019 On the first hit, the block SHALL load action with the empty cell's index and go to HOLD; after L7 with no hit, it SHALL go to BLOCK with the line counter cleared.
REQ-020 BLOCK SHALL be identical to WIN, using the opponent code; after L7 with no hit, it SHALL go to CENTER.
REQ-021 CENTER, one cycle: if cell 4 is empty, action=4 and next state is HOLD; otherwise the block SHALL go to RAND.
REQ-022 On RAND entry, the start index SHALL be lfsr[3:0], minus 9 if that value is >=9.
REQ-023 RAND SHALL probe one cell per cycle, index incrementing with wrap 8->0, at most 9 probes; the first empty cell gives action and next state HOLD.
REQ-024 If all 9 RAND probes find occupied cells, the block SHALL pulse no_move for one cycle and go to IDLE.
REQ-025 HOLD: action_valid=1 and action SHALL be stable; when action_ready=1 the block SHALL go to IDLE, with action_valid low on the next cycle.
REQ-026 Latency: a hit on line k in WIN SHALL give action_valid high k+2 cycles after the req edge.
REQ-027 Abort: outcome!=0, or enable=0, in any non-IDLE state SHALL force IDLE next cycle with no action_valid and no no_move; abort has priority over a hit in the same cycle.
REQ-028 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, stepping every cycle while enable=1.

Reset
REQ-029 While rst_n=0: state=IDLE, action=0, action_valid=0, busy=0, no_move=0, snapshot=0, counters=0, LFSR=LFSR_SEED (or 8'h01 if LFSR_SEED=0).
REQ-030 Reset assertion mid-search or in HOLD SHALL drop action_valid immediately, without waiting for a clock edge.
REQ-031 rst_policygen=1 SHALL give the REQ-029 values at the next edge, and SHALL take priority over req.

Structure
REQ-032 A shared package SHALL hold the cell codes (EMPTY, AGENT, PLAYER), the outcome codes, the 8x3 line-to-cell table, and the FSM state enumeration.
REQ-033 One sub-module, line_eval, SHALL be used: combinational, takes three cells and a mark, returns hit plus the empty position (0..2).

Verification
REQ-034 Snapshot with cells 0,1 = agent and cell 2 empty, req pulse -> action=2, action_valid high 2 cycles after the req edge.
REQ-035 Snapshot with cells 3,4 = player, no agent threat, cell 5 empty -> action=5, reached through BLOCK.
REQ-036 Empty board -> action=4 from CENTER, valid 18 cycles after req; holding action_ready=0 for 5 cycles -> action and valid held stable.
REQ-037 Full board with no line completed -> no_move single pulse after 9 RAND probes, action_valid never high.
REQ-038 outcome=2'b10 raised during BLOCK -> IDLE next cycle, busy=0, no action_valid.
REQ-039 rst_n dropped in HOLD -> action_valid low immediately; after release, LFSR=8'hA5 and the same snapshot reproduces the same RAND choice.

Source files
------------

// File: rtl/policy_gen_pkg.sv
// Shared definitions for the tic-tac-toe move policy block.
// Holds the cell and outcome codes, the line-to-cell table, the FSM state
// encoding and small helpers used by policy_gen.
package policy_gen_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_AGENT  = 2'b01;
  localparam logic [1:0] CELL_PLAYER = 2'b10;

  localparam logic [1:0] OUTCOME_NONE       = 2'b00;
  localparam logic [1:0] OUTCOME_AGENT_WIN  = 2'b01;
  localparam logic [1:0] OUTCOME_PLAYER_WIN = 2'b10;
  localparam logic [1:0] OUTCOME_DRAW       = 2'b11;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] LINE_TABLE [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WIN    = 3'd1;
  localparam logic [2:0] ST_BLOCK  = 3'd2;
  localparam logic [2:0] ST_CENTER = 3'd3;
  localparam logic [2:0] ST_RAND   = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    WIN    = ST_WIN,
    BLOCK  = ST_BLOCK,
    CENTER = ST_CENTER,
    RAND   = ST_RAND,
    HOLD   = ST_HOLD
  } state_t;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] mod9(input logic [3:0] v);
    return (v >= 4'd9) ? (v - 4'd9) : v;
  endfunction

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/policy_gen_if.sv
// Move request / action handshake between a requester and policy_gen.
//   req          : move request (requester -> policy)
//   action_ready : requester accepts the presented action
//   action       : chosen cell index 0..8
//   action_valid : action holds a legal move
//   busy         : policy is searching or holding a move
//   no_move      : one-cycle pulse, snapshot had no empty cell
interface policy_gen_if;
  logic       req;
  logic       action_ready;
  logic [3:0] action;
  logic       action_valid;
  logic       busy;
  logic       no_move;

  modport master (
    output req, action_ready,
    input  action, action_valid, busy, no_move
  );

  modport slave (
    input  req, action_ready,
    output action, action_valid, busy, no_move
  );
endinterface

// File: rtl/policy_gen_line_eval.sv
// Combinational evaluation of one three-cell line.
//   c0..c2 : cell codes along the line
//   mark   : mark being looked for
//   hit    : two cells hold mark and the remaining cell is empty
//   pos    : position (0..2) of the empty cell when hit is set
module line_eval
  import policy_gen_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] pos
);

  always_comb begin
    hit = 1'b0;
    pos = '0;
    if (c0 == CELL_EMPTY && c1 == mark && c2 == mark) begin
      hit = 1'b1;
      pos = 2'd0;
    end else if (c0 == mark && c1 == CELL_EMPTY && c2 == mark) begin
      hit = 1'b1;
      pos = 2'd1;
    end else if (c0 == mark && c1 == mark && c2 == CELL_EMPTY) begin
      hit = 1'b1;
      pos = 2'd2;
    end
  end

endmodule

// File: rtl/policy_gen.sv
// Move policy: on request, snapshots the board and picks a cell by
// priority: complete own line, block opponent line, take centre, else
// probe from an LFSR-chosen start for the first empty cell.
//   clock, rst_n  : clock, asynchronous active-low reset
//   enable        : low holds the FSM idle and freezes the LFSR
//   rst_policygen : synchronous clear
//   board         : 9 cells x 2 bits, cell i at [2i+1:2i]
//   outcome       : nonzero when the game is over
//   pif           : request/action handshake (slave side)
module policy_gen
  import policy_gen_pkg::*;
#(
  parameter logic [1:0] OWN_MARK  = 2'd1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          rst_policygen,
  input  logic [17:0]   board,
  input  logic [1:0]    outcome,
  policy_gen_if.slave   pif
);

  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t      state;
  logic [17:0] snapshot;
  logic [2:0]  line_idx;
  logic [3:0]  probe_idx;
  logic [3:0]  probe_cnt;
  logic [7:0]  lfsr;
  logic [3:0]  action;
  logic        action_valid;
  logic        no_move;

  logic [1:0]  c0, c1, c2, mark;
  logic        hit;
  logic [1:0]  pos;
  logic        abort;

  always_comb begin
    c0    = cell_at(snapshot, LINE_TABLE[line_idx][0]);
    c1    = cell_at(snapshot, LINE_TABLE[line_idx][1]);
    c2    = cell_at(snapshot, LINE_TABLE[line_idx][2]);
    mark  = (state == BLOCK) ? ~OWN_MARK : OWN_MARK;
    abort = (outcome != OUTCOME_NONE) || !enable;
  end

  line_eval u_line_eval (
    .c0   (c0),
    .c1   (c1),
    .c2   (c2),
    .mark (mark),
    .hit  (hit),
    .pos  (pos)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      snapshot     <= '0;
      line_idx     <= '0;
      probe_idx    <= '0;
      probe_cnt    <= '0;
      lfsr         <= SEED;
      action       <= '0;
      action_valid <= 1'b0;
      no_move      <= 1'b0;
    end else if (rst_policygen) begin
      state        <= IDLE;
      snapshot     <= '0;
      line_idx     <= '0;
      probe_idx    <= '0;
      probe_cnt    <= '0;
      lfsr         <= SEED;
      action       <= '0;
      action_valid <= 1'b0;
      no_move      <= 1'b0;
    end else begin
      if (enable) lfsr <= lfsr_next(lfsr);
      no_move <= 1'b0;
      // Abort wins over any hit or probe result in the same cycle.
      if (state != IDLE && abort) begin
        state        <= IDLE;
        action_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pif.req && enable && outcome == OUTCOME_NONE) begin
              snapshot <= board;
              line_idx <= '0;
              state    <= WIN;
            end
          end
          WIN, BLOCK: begin
            if (hit) begin
              action <= LINE_TABLE[line_idx][pos];
              state  <= HOLD;
            end else if (line_idx == 3'd7) begin
              line_idx <= '0;
              state    <= (state == WIN) ? BLOCK : CENTER;
            end else begin
              line_idx <= line_idx + 3'd1;
            end
          end
          CENTER: begin
            if (cell_at(snapshot, 4'd4) == CELL_EMPTY) begin
              action <= 4'd4;
              state  <= HOLD;
            end else begin
              probe_idx <= mod9(lfsr[3:0]);
              probe_cnt <= '0;
              state     <= RAND;
            end
          end
          RAND: begin
            if (cell_at(snapshot, probe_idx) == CELL_EMPTY) begin
              action <= probe_idx;
              state  <= HOLD;
            end else if (probe_cnt == 4'd8) begin
              no_move <= 1'b1;
              state   <= IDLE;
            end else begin
              probe_idx <= (probe_idx == 4'd8) ? 4'd0 : probe_idx + 4'd1;
              probe_cnt <= probe_cnt + 4'd1;
            end
          end
          HOLD: begin
            // First HOLD cycle raises valid, so a hit on line k is
            // presented k+2 cycles after the request is taken.
            if (action_valid && pif.action_ready) begin
              action_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              action_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pif.action       = action;
  assign pif.action_valid = action_valid;
  assign pif.busy         = (state != IDLE);
  assign pif.no_move      = no_move;

endmodule

// File: tb/tb_policy_gen.sv
module tb_policy_gen;
  import policy_gen_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        rst_policygen;
  logic [17:0] board;
  logic [1:0]  outcome;

  policy_gen_if pif();

  policy_gen #(.OWN_MARK(2'd1), .LFSR_SEED(8'hA5)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .enable        (enable),
    .rst_policygen (rst_policygen),
    .board         (board),
    .outcome       (outcome),
    .pif           (pif)
  );

  always #5 clock = ~clock;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5.
  logic [7:0] m_lfsr;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)             m_lfsr <= 8'hA5;
    else if (rst_policygen) m_lfsr <= 8'hA5;
    else if (enable)        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Returns one time unit after the edge that samples req.
  task automatic do_req(input logic [17:0] b);
    board   = b;
    pif.req = 1'b1;
    @(posedge clock);
    #1;
    pif.req = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (pif.action_valid !== 1'b1 && cyc < 80) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #7;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] exp_rand(input logic [17:0] b, input logic [7:0] l, output int steps);
    int unsigned s;
    s = (l[3:0] >= 4'd9) ? int'(l[3:0]) - 9 : int'(l[3:0]);
    for (int i = 0; i < 9; i++) begin
      int unsigned c;
      c = (s + i) % 9;
      if (b[2*c +: 2] == 2'b00) begin
        steps = i;
        return c[3:0];
      end
    end
    steps = 9;
    return 4'hF;
  endfunction

  // Search a RAND-only snapshot, checking latency and choice against the model.
  task automatic run_rand(input logic [17:0] b, input string tag, output logic [3:0] exp_a);
    int cyc, steps;
    logic [7:0] lv;
    do_req(b);
    tick(16);
    lv    = m_lfsr;
    exp_a = exp_rand(b, lv, steps);
    wait_valid(16, cyc);
    chk({tag, "_lat"}, cyc, 19 + steps);
    chk({tag, "_act"}, pif.action, exp_a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, pulses, first_pulse;
    logic seen_valid;
    logic [3:0] a1, a2;
    logic [17:0] b_rand;

    rst_n = 1'b0; enable = 1'b1; rst_policygen = 1'b0;
    board = '0; outcome = '0;
    pif.req = 1'b0; pif.action_ready = 1'b0;
    #12;
    chk("rst_action", pif.action, 4'd0);
    chk("rst_valid", pif.action_valid, 1'b0);
    chk("rst_busy", pif.busy, 1'b0);
    chk("rst_no_move", pif.no_move, 1'b0);
    chk("rst_lfsr", dut.lfsr, 8'hA5);
    @(negedge clock);
    rst_n = 1'b1;

    // Own line L0: cells 0,1 agent, 2 empty; board change after req ignored.
    do_req({2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01});
    board = '0;
    chk("win_busy", pif.busy, 1'b1);
    tick(1);
    chk("win_early_valid", pif.action_valid, 1'b0);
    wait_valid(1, cyc);
    chk("win_lat", cyc, 2);
    chk("win_act", pif.action, 4'd2);
    pif.action_ready = 1'b1;
    tick(1);
    chk("win_release_valid", pif.action_valid, 1'b0);
    chk("win_release_busy", pif.busy, 1'b0);
    pif.action_ready = 1'b0;

    // Block opponent L1: cells 3,4 player, 5 empty.
    do_req({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00});
    wait_valid(0, cyc);
    chk("block_lat", cyc, 11);
    chk("block_act", pif.action, 4'd5);
    pif.action_ready = 1'b1;
    tick(1);
    pif.action_ready = 1'b0;

    // Empty board: centre, then hold while not accepted.
    do_req('0);
    wait_valid(0, cyc);
    chk("center_lat", cyc, 18);
    chk("center_act", pif.action, 4'd4);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_valid", pif.action_valid, 1'b1);
      chk("hold_act", pif.action, 4'd4);
    end
    pif.action_ready = 1'b1;
    tick(1);
    chk("center_release", pif.action_valid, 1'b0);
    pif.action_ready = 1'b0;

    // Full board: no_move pulse after nine probes.
    do_req({2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01});
    pulses = 0; first_pulse = -1; seen_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (pif.no_move === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      if (pif.action_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("full_pulses", pulses, 1);
    chk("full_pulse_cycle", first_pulse, 26);
    chk("full_no_valid", seen_valid, 1'b0);
    chk("full_busy", pif.busy, 1'b0);

    // Outcome raised during BLOCK aborts; req ignored while game over.
    do_req('0);
    tick(10);
    chk("abort_pre_busy", pif.busy, 1'b1);
    outcome = 2'b10;
    tick(1);
    chk("abort_busy", pif.busy, 1'b0);
    chk("abort_valid", pif.action_valid, 1'b0);
    do_req('0);
    chk("gameover_req_busy", pif.busy, 1'b0);
    outcome = 2'b00;

    // enable drop beats a hit in the same cycle.
    do_req({2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01});
    enable = 1'b0;
    tick(1);
    chk("disable_busy", pif.busy, 1'b0);
    tick(3);
    chk("disable_valid", pif.action_valid, 1'b0);
    enable = 1'b1;

    // Synchronous clear mid-search, also outranking req.
    do_req('0);
    tick(3);
    rst_policygen = 1'b1;
    do_req('0);
    chk("clr_busy", pif.busy, 1'b0);
    chk("clr_lfsr", dut.lfsr, 8'hA5);
    rst_policygen = 1'b0;

    // RAND choice reproducible after async reset; reset drops valid at once.
    b_rand = {2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    reset_pulse();
    run_rand(b_rand, "rand1", a1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", pif.action_valid, 1'b0);
    chk("async_busy", pif.busy, 1'b0);
    chk("async_lfsr", dut.lfsr, 8'hA5);
    @(negedge clock);
    rst_n = 1'b1;
    run_rand(b_rand, "rand2", a2);
    chk("rand_repeat", pif.action, a1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
